// File: rtl/antidroop_iir_mc_if.sv
// Sample/control bundle between the ADC deserialiser (master) and the
// multi-channel anti-droop filter (slave).
interface antidroop_iir_mc_if #(
   parameter int NCH = 2,
   parameter int DW  = 16,
   parameter int TW  = 7
);
   logic                trig;
   logic [NCH*DW-1:0]   din;
   logic [NCH*TW-1:0]   tap_weight;
   logic                acc_clr_en;
   logic                bypass;
   logic                oflow_clr;
   logic [NCH-1:0]      oflow_detect;
   logic [NCH*DW-1:0]   dout;

   modport master (
      output trig, din, tap_weight, acc_clr_en, bypass, oflow_clr,
      input  oflow_detect, dout
   );

   modport slave (
      input  trig, din, tap_weight, acc_clr_en, bypass, oflow_clr,
      output oflow_detect, dout
   );
endinterface

// File: rtl/antidroop_iir_mc.sv
// Multi-channel anti-droop IIR: each channel adds a scaled running integral of its
// own input back onto that input, with saturation, bypass and sticky overflow flags.
module antidroop_iir_mc #(
   parameter int NCH       = 2,
   parameter int DW        = 16,
   parameter int TW        = 7,
   parameter int IIR_SCALE = 15,
   parameter int ACC_W     = 48,
   parameter bit SAT_EN    = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   antidroop_iir_mc_if.slave  bus
);

   localparam logic signed [DW-1:0] DOUT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] DOUT_MIN = {1'b1, {(DW-1){1'b0}}};

   logic trig_a, trig_b;
   logic trig_edge;
   logic acc_zero;

   // trig is asynchronous to the sample clock; two flops before edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_a <= 1'b0;
         trig_b <= 1'b0;
      end else begin
         // NOTE: non-blocking so trig_b samples the old trig_a, forming the edge detector.
         trig_a <= bus.trig;
         trig_b <= trig_a;
      end
   end

   assign trig_edge = trig_a & ~trig_b;
   assign acc_zero  = (trig_edge & bus.acc_clr_en) | bus.bypass;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic signed [DW-1:0]    din_c;
      logic signed [TW-1:0]    w_a, w_b, w_act;
      logic signed [DW-1:0]    din_d;
      logic signed [DW+TW-1:0] prod;
      logic signed [ACC_W-1:0] acc;
      logic signed [DW-1:0]    dout_q;
      logic                    oflow_q;
      logic signed [DW:0]      sum;
      logic                    sat_hi, sat_lo;
      logic signed [DW-1:0]    sum_lim;
      logic                    oflow_set;

      assign din_c = bus.din[c*DW +: DW];

      always_comb begin
         // NOTE: every output gets a value on every path, otherwise a latch is inferred.
         sum     = {din_d[DW-1], din_d}
                 + {acc[IIR_SCALE+DW-1], acc[IIR_SCALE+DW-1:IIR_SCALE]};
         sat_hi  = ~sum[DW] &  sum[DW-1];
         sat_lo  =  sum[DW] & ~sum[DW-1];
         sum_lim = sum[DW-1:0];
         if (SAT_EN) begin
            if (sat_hi)      sum_lim = DOUT_MAX;
            else if (sat_lo) sum_lim = DOUT_MIN;
         end
         // Slice wrap is judged on the bit just above the extracted slice.
         oflow_set = (acc[IIR_SCALE+DW] ^ acc[IIR_SCALE+DW-1])
                   | (SAT_EN & ~bus.bypass & (sat_hi | sat_lo));
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: all pipeline and weight state is reset so a mid-pulse reset leaves no residue.
            w_a     <= '0;
            w_b     <= '0;
            w_act   <= '0;
            din_d   <= '0;
            prod    <= '0;
            acc     <= '0;
            dout_q  <= '0;
            oflow_q <= 1'b0;
         end else begin
            w_a <= bus.tap_weight[c*TW +: TW];
            w_b <= w_a;
            if (trig_edge) w_act <= w_b;

            din_d <= din_c;
            prod  <= (DW+TW)'(din_c) * (DW+TW)'(w_act);

            // Clear beats accumulate; the product in flight is dropped.
            if (acc_zero) acc <= '0;
            else          acc <= acc + ACC_W'(prod);

            dout_q <= bus.bypass ? din_d : sum_lim;

            if (bus.oflow_clr)  oflow_q <= 1'b0;
            else if (oflow_set) oflow_q <= 1'b1;
         end
      end

      assign bus.dout[c*DW +: DW] = dout_q;
      assign bus.oflow_detect[c]  = oflow_q;
   end

endmodule

// File: tb/tb_antidroop_iir_mc.sv
// Directed bench for antidroop_iir_mc (NCH=2, DW=16, TW=7, IIR_SCALE=15, SAT_EN=1);
// expected values are hand-derived from the filter recurrence.
module tb_antidroop_iir_mc;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   antidroop_iir_mc_if #(.NCH(2), .DW(16), .TW(7)) bus ();

   antidroop_iir_mc #(
      .NCH(2), .DW(16), .TW(7), .IIR_SCALE(15), .ACC_W(48), .SAT_EN(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int d0();
      logic signed [15:0] v;
      v = bus.dout[15:0];
      return int'(v);
   endfunction

   function automatic int d1();
      logic signed [15:0] v;
      v = bus.dout[31:16];
      return int'(v);
   endfunction

   function automatic int f0();
      return int'(bus.oflow_detect[0]);
   endfunction

   function automatic int f1();
      return int'(bus.oflow_detect[1]);
   endfunction

   initial begin
      rst_n          = 1'b0;
      bus.trig       = 1'b0;
      bus.din        = {16'sd0, 16'sd1000};
      bus.tap_weight = {7'sd0, 7'sd63};
      bus.acc_clr_en = 1'b0;
      bus.bypass     = 1'b0;
      bus.oflow_clr  = 1'b0;
      #12 rst_n = 1'b1;

      // Reset state and transparent behaviour before any trigger
      check("rst_dout0", d0(), 0);
      check("rst_flags", int'(bus.oflow_detect), 0);
      step(1);
      check("lat1_dout0", d0(), 0);
      step(1);
      check("lat2_dout0", d0(), 1000);

      // Weight 63 on a cleared pulse: dout = 1000 + floor(63000k/32768)
      bus.trig       = 1'b1;
      bus.acc_clr_en = 1'b1;
      step(5);
      check("k1_dout0", d0(), 1001);
      bus.trig = 1'b0;
      step(9);
      check("k10_dout0", d0(), 1019);

      // Weight change mid-pulse has no effect until the next trigger edge
      bus.tap_weight = {7'sd0, -7'sd20};
      step(10);
      check("k20_dout0", d0(), 1038);

      // Edge without clear: accumulation continues, slope becomes -20000/clk
      bus.acc_clr_en = 1'b0;
      bus.trig       = 1'b1;
      step(14);
      check("reload_j10", d0(), 1040);
      bus.trig = 1'b0;
      step(20);
      check("reload_j30", d0(), 1027);

      // Edge with clear: dout returns to din two clk after the edge
      bus.acc_clr_en = 1'b1;
      bus.trig       = 1'b1;
      step(3);
      check("clr_dout0", d0(), 1000);

      // Positive saturation on ch0 only
      bus.trig       = 1'b0;
      bus.tap_weight = {7'sd0, 7'sd63};
      bus.din        = {16'sd0, 16'sd32000};
      step(3);
      bus.trig = 1'b1;
      step(30);
      check("sat_dout0", d0(), 32767);
      check("sat_flag0", f0(), 1);
      check("sat_flag1", f1(), 0);
      check("sat_dout1", d1(), 0);

      // oflow_clr clears for one clk, then the persisting saturation re-sets it
      bus.oflow_clr = 1'b1;
      step(1);
      check("clr_flag0", f0(), 0);
      bus.oflow_clr = 1'b0;
      step(1);
      check("reset_flag0", f0(), 1);
      step(5);
      check("sticky_flag0", f0(), 1);
      check("sticky_flag1", f1(), 0);

      // Negative saturation on ch1
      bus.trig       = 1'b0;
      bus.tap_weight = {7'sd63, 7'sd63};
      bus.din        = {-16'sd32000, 16'sd32000};
      step(3);
      bus.trig = 1'b1;
      step(30);
      check("neg_dout1", d1(), -32768);
      check("neg_flag1", f1(), 1);
      check("pos_dout0", d0(), 32767);

      // Bypass: dout follows din with the same two-clk latency
      bus.bypass = 1'b1;
      bus.din    = {-16'sd555, 16'sd1234};
      step(1);
      check("byp1_dout0", d0(), 32000);
      step(1);
      check("byp2_dout0", d0(), 1234);
      check("byp2_dout1", d1(), -555);
      check("byp_flag0", f0(), 1);

      // Asynchronous reset mid-pulse
      #2 rst_n = 1'b0;
      #1;
      check("arst_dout0", d0(), 0);
      check("arst_dout1", d1(), 0);
      check("arst_flags", int'(bus.oflow_detect), 0);
      bus.trig   = 1'b0;
      bus.bypass = 1'b0;
      bus.din    = {16'sd0, 16'sd1000};
      #3 rst_n = 1'b1;
      step(1);
      check("post_lat1", d0(), 0);
      step(1);
      check("post_lat2", d0(), 1000);
      step(5);
      check("post_idle", d0(), 1000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
